// File: rtl/universal_register.sv
// Universal register: load, shift, rotate, up/down count with carry/borrow and zero status.
// Latency: one cycle from enabling edge to A; no backpressure, enable=0 simply holds all state.
module universal_register #(
  parameter int WIDTH      = 4,
  parameter bit STRUCTURAL = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             serial_right_in,
  input  logic             serial_left_in,
  output logic [WIDTH-1:0] A,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] a_q, a_d;
  logic             carry_q, carry_d;

  if (!STRUCTURAL) begin : g_behav
    always_comb begin
      a_d     = a_q;
      carry_d = carry_q;
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          a_d     = I;
          carry_d = 1'b0;
        end
        MODE_SHR: begin
          a_d     = {serial_right_in, a_q[WIDTH-1:1]};
          carry_d = a_q[0];
        end
        MODE_SHL: begin
          a_d     = {a_q[WIDTH-2:0], serial_left_in};
          carry_d = a_q[WIDTH-1];
        end
        MODE_ROR: begin
          a_d     = {a_q[0], a_q[WIDTH-1:1]};
          carry_d = a_q[0];
        end
        MODE_ROL: begin
          a_d     = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
          carry_d = a_q[WIDTH-1];
        end
        MODE_INC: {carry_d, a_d} = {1'b0, a_q} + (WIDTH+1)'(1);
        MODE_DEC: begin
          a_d     = a_q - WIDTH'(1);
          carry_d = (a_q == '0);
        end
        default: ;
      endcase
    end
  end else begin : g_struct
    logic [WIDTH-1:0] shr_v, shl_v, ror_v, rol_v, inc_v, dec_v;
    logic [WIDTH:0]   inc_c, bor_c;
    logic [7:0]       carry_sel;

    // Ripple chains: inc_c[i] = all lower bits are 1, bor_c[i] = all lower bits are 0.
    always_comb begin
      inc_c[0] = 1'b1;
      bor_c[0] = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
        inc_c[i+1] = inc_c[i] & a_q[i];
        bor_c[i+1] = bor_c[i] & ~a_q[i];
      end
    end

    assign shr_v = {serial_right_in, a_q[WIDTH-1:1]};
    assign shl_v = {a_q[WIDTH-2:0], serial_left_in};
    assign ror_v = {a_q[0], a_q[WIDTH-1:1]};
    assign rol_v = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
    assign inc_v = a_q ^ inc_c[WIDTH-1:0];
    assign dec_v = a_q ^ bor_c[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [7:0] sel;
      assign sel    = {dec_v[i], inc_v[i], rol_v[i], ror_v[i],
                       shl_v[i], shr_v[i], I[i], a_q[i]};
      assign a_d[i] = sel[mode];
    end

    assign carry_sel = {bor_c[WIDTH], inc_c[WIDTH], a_q[WIDTH-1], a_q[0],
                        a_q[WIDTH-1], a_q[0], 1'b0, carry_q};
    assign carry_d   = carry_sel[mode];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      a_q     <= '0;
      carry_q <= 1'b0;
    end else if (enable) begin
      a_q     <= a_d;
      carry_q <= carry_d;
    end
  end

  assign A         = a_q;
  assign carry_out = carry_q;
  assign zero      = (a_q == '0);

endmodule

// File: tb/tb_universal_register.sv
module tb_universal_register;
  logic       clk;
  logic       clear;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] I;
  logic       serial_right_in;
  logic       serial_left_in;

  logic [3:0] a4b, a4s;
  logic [7:0] a8b, a8s;
  logic       c4b, c4s, c8b, c8s;
  logic       z4b, z4s, z8b, z8s;

  int total = 0;
  int bad   = 0;

  universal_register #(.WIDTH(4), .STRUCTURAL(1'b0)) u_b4 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .I(I[3:0]),
    .serial_right_in(serial_right_in), .serial_left_in(serial_left_in),
    .A(a4b), .carry_out(c4b), .zero(z4b));
  universal_register #(.WIDTH(4), .STRUCTURAL(1'b1)) u_s4 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .I(I[3:0]),
    .serial_right_in(serial_right_in), .serial_left_in(serial_left_in),
    .A(a4s), .carry_out(c4s), .zero(z4s));
  universal_register #(.WIDTH(8), .STRUCTURAL(1'b0)) u_b8 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .I(I),
    .serial_right_in(serial_right_in), .serial_left_in(serial_left_in),
    .A(a8b), .carry_out(c8b), .zero(z8b));
  universal_register #(.WIDTH(8), .STRUCTURAL(1'b1)) u_s8 (
    .clk(clk), .clear(clear), .enable(enable), .mode(mode), .I(I),
    .serial_right_in(serial_right_in), .serial_left_in(serial_left_in),
    .A(a8s), .carry_out(c8s), .zero(z8s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] d);
    enable = 1'b1;
    mode   = m;
    I      = d;
    tick();
  endtask

  // Behavioural and structural variants must agree every cycle.
  always @(negedge clk) begin
    chk("x4_A",     {4'h0, a4s}, {4'h0, a4b});
    chk("x4_carry", {7'h0, c4s}, {7'h0, c4b});
    chk("x4_zero",  {7'h0, z4s}, {7'h0, z4b});
    chk("x8_A",     a8s,         a8b);
    chk("x8_carry", {7'h0, c8s}, {7'h0, c8b});
    chk("x8_zero",  {7'h0, z8s}, {7'h0, z8b});
  end

  initial begin
    clear           = 1'b1;
    enable          = 1'b0;
    mode            = 3'b000;
    I               = 8'h00;
    serial_right_in = 1'b0;
    serial_left_in  = 1'b0;
    #3;
    chk("rst_A",     {4'h0, a4b}, 8'h00);
    chk("rst_zero",  {7'h0, z4b}, 8'h01);
    chk("rst_carry", {7'h0, c4b}, 8'h00);
    chk("rst_A8",    a8b,         8'h00);

    // Clear must win over an enabled load at the edge.
    enable = 1'b1;
    mode   = 3'b001;
    I      = 8'h0F;
    tick();
    chk("clr_prio_A", {4'h0, a4b}, 8'h00);
    @(negedge clk);
    clear = 1'b0;

    op(3'b001, 8'h0A);
    chk("load_A",    {4'h0, a4b}, 8'h0A);
    chk("load_zero", {7'h0, z4b}, 8'h00);
    enable = 1'b0;
    mode   = 3'b110;
    tick();
    chk("en0_A", {4'h0, a4b}, 8'h0A);

    // Shift right
    op(3'b001, 8'h0B);
    serial_right_in = 1'b0;
    op(3'b010, 8'h00);
    chk("shr1_A", {4'h0, a4b}, 8'h05);
    chk("shr1_c", {7'h0, c4b}, 8'h01);
    serial_right_in = 1'b1;
    op(3'b010, 8'h00);
    chk("shr2_A", {4'h0, a4b}, 8'h0A);
    chk("shr2_c", {7'h0, c4b}, 8'h01);

    // Shift left, then rotates with serial inputs set against the rotated bit
    op(3'b001, 8'h09);
    serial_left_in = 1'b1;
    op(3'b011, 8'h00);
    chk("shl_A", {4'h0, a4b}, 8'h03);
    chk("shl_c", {7'h0, c4b}, 8'h01);
    serial_right_in = 1'b0;
    serial_left_in  = 1'b0;
    op(3'b100, 8'h00);
    chk("ror_A", {4'h0, a4b}, 8'h09);
    chk("ror_c", {7'h0, c4b}, 8'h01);
    op(3'b101, 8'h00);
    chk("rol_A", {4'h0, a4b}, 8'h03);
    chk("rol_c", {7'h0, c4b}, 8'h01);
    op(3'b001, 8'h00);
    chk("load_clrc", {7'h0, c4b}, 8'h00);

    // Count wrap both directions
    op(3'b001, 8'h0E);
    op(3'b110, 8'h00);
    chk("inc1_A", {4'h0, a4b}, 8'h0F);
    chk("inc1_c", {7'h0, c4b}, 8'h00);
    op(3'b110, 8'h00);
    chk("inc2_A", {4'h0, a4b}, 8'h00);
    chk("inc2_c", {7'h0, c4b}, 8'h01);
    chk("inc2_z", {7'h0, z4b}, 8'h01);
    op(3'b000, 8'h05);
    chk("hold_A", {4'h0, a4b}, 8'h00);
    chk("hold_c", {7'h0, c4b}, 8'h01);
    op(3'b111, 8'h00);
    chk("dec1_A", {4'h0, a4b}, 8'h0F);
    chk("dec1_c", {7'h0, c4b}, 8'h01);
    op(3'b111, 8'h00);
    chk("dec2_A", {4'h0, a4b}, 8'h0E);
    chk("dec2_c", {7'h0, c4b}, 8'h00);

    // Asynchronous clear in the middle of a count
    op(3'b001, 8'h00);
    for (int k = 0; k < 5; k++) op(3'b110, 8'h00);
    chk("cnt5_A", {4'h0, a4b}, 8'h05);
    clear = 1'b1;
    #1;
    chk("aclr_A", {4'h0, a4b}, 8'h00);
    chk("aclr_z", {7'h0, z4b}, 8'h01);
    chk("aclr_c", {7'h0, c4b}, 8'h00);
    #1;
    clear = 1'b0;
    op(3'b110, 8'h00);
    chk("postclr_A", {4'h0, a4b}, 8'h01);

    // Eight-bit instance
    op(3'b001, 8'hFF);
    chk("w8_load", a8b, 8'hFF);
    op(3'b110, 8'h00);
    chk("w8_inc_A", a8b, 8'h00);
    chk("w8_inc_c", {7'h0, c8b}, 8'h01);
    op(3'b001, 8'h80);
    serial_right_in = 1'b1;
    op(3'b010, 8'h00);
    chk("w8_shr_A", a8b, 8'hC0);
    chk("w8_shr_c", {7'h0, c8b}, 8'h00);
    op(3'b111, 8'h00);
    chk("w8_dec_A", a8b, 8'hBF);
    chk("w8_dec_c", {7'h0, c8b}, 8'h00);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
